// File: rtl/pc_sequencer_pkg.sv
// Shared types, select codes and default addresses for the fetch-PC sequencer.
package pc_sequencer_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    NPC_PC4    = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JR     = 3'd3
  } npc_sel_e;

  localparam addr_t       DEF_INIT_ADDR = 32'h0000_3000;
  localparam addr_t       DEF_TRAP_ADDR = 32'h0000_4180;
  localparam int unsigned DEF_LINK_OFF  = 8;
  localparam int unsigned DEF_RAS_DEPTH = 4;
  localparam addr_t       TEXT_LO       = 32'h0000_3000;
  localparam addr_t       TEXT_HI       = 32'h0000_6ffc;

  // Delay-slot branch target: PC of the branch + 4 + word offset.
  function automatic addr_t branch_target(input addr_t pc, input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  addr_t                    push_val_i,
  output addr_t                    top_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  addr_t             entries_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;

  // ptr_q names the next free slot; the top lives just below it.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_i && pop_i) begin
      wr_en = 1'b1;
      if (cnt_q == '0) begin
        ptr_d = ptr_q + PTR_W'(1);
        cnt_d = CNT_W'(1);
      end else begin
        wr_idx = ptr_q - PTR_W'(1);
      end
    end else if (push_i) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      entries_q <= '{default: '0};
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_en) entries_q[wr_idx] <= push_val_i;
    end
  end

  assign top_o = (cnt_q == '0) ? '0 : entries_q[ptr_q - PTR_W'(1)];
  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC owner: next-PC selection, trap/eret redirect and RAS return checking.
// Define ADDR_CHECK_EN to build the fetch address-error comparators.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter addr_t       INIT_ADDR = DEF_INIT_ADDR,
  parameter addr_t       TRAP_ADDR = DEF_TRAP_ADDR,
  parameter int unsigned LINK_OFF  = DEF_LINK_OFF,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          int_req,
  input  logic                          eret,
  input  logic [31:0]                   epc,
  input  logic [2:0]                    npc_sel,
  input  logic                          D_bjump,
  input  logic [31:0]                   D_PC,
  input  logic [15:0]                   D_imm16,
  input  logic [25:0]                   D_imm26,
  input  logic [31:0]                   D_ra,
  input  logic                          D_call,
  input  logic                          D_ret,
  output logic [31:0]                   F_PC,
  output logic [31:0]                   ras_top,
  output logic [$clog2(RAS_DEPTH):0]    ras_cnt,
  output logic                          ras_miss,
  output logic                          F_exc_adel
);

  addr_t pc_q, pc_d;
  logic  ras_upd;

  // Trap beats stall; stall beats eret and the normal select.
  always_comb begin
    pc_d = pc_q;
    if (int_req) begin
      pc_d = TRAP_ADDR;
    end else if (!stall) begin
      if (eret) begin
        pc_d = epc;
      end else begin
        case (npc_sel)
          NPC_PC4:    pc_d = pc_q + 32'd4;
          NPC_BRANCH: pc_d = D_bjump ? branch_target(D_PC, D_imm16) : pc_q + 32'd4;
          NPC_JUMP:   pc_d = {D_PC[31:28], D_imm26, 2'b00};
          NPC_JR:     pc_d = D_ra;
          default:    pc_d = INIT_ADDR;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= INIT_ADDR;
    else       pc_q <= pc_d;
  end

  assign F_PC    = pc_q;
  assign ras_upd = !int_req && !stall;

  pc_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk        (clk),
    .rst        (reset),
    .push_i     (ras_upd && D_call),
    .pop_i      (ras_upd && D_ret),
    .push_val_i (D_PC + ADDR_W'(LINK_OFF)),
    .top_o      (ras_top),
    .cnt_o      (ras_cnt)
  );

  // Informational only: the redirect always follows D_ra.
  assign ras_miss = D_ret && ras_upd && ((ras_cnt == '0) || (ras_top != D_ra));

`ifdef ADDR_CHECK_EN
  assign F_exc_adel = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
`else
  assign F_exc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, int_req, eret, D_bjump, D_call, D_ret;
  logic [31:0] epc, D_PC, D_ra;
  logic [2:0]  npc_sel;
  logic [15:0] D_imm16;
  logic [25:0] D_imm26;
  logic [31:0] F_PC, ras_top;
  logic [2:0]  ras_cnt;
  logic        ras_miss, F_exc_adel;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .int_req(int_req), .eret(eret),
    .epc(epc), .npc_sel(npc_sel), .D_bjump(D_bjump), .D_PC(D_PC),
    .D_imm16(D_imm16), .D_imm26(D_imm26), .D_ra(D_ra), .D_call(D_call),
    .D_ret(D_ret), .F_PC(F_PC), .ras_top(ras_top), .ras_cnt(ras_cnt),
    .ras_miss(ras_miss), .F_exc_adel(F_exc_adel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_adel(input logic [31:0] pc);
`ifdef ADDR_CHECK_EN
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6ffc);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_top();
    return (m_ras.size() == 0) ? 32'h0 : m_ras[$];
  endfunction

  task automatic clear_inputs();
    stall = 0; int_req = 0; eret = 0; epc = 0; npc_sel = 3'd0; D_bjump = 0;
    D_PC = 32'h3000; D_imm16 = 0; D_imm26 = 0; D_ra = 0; D_call = 0; D_ret = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".F_PC"},  F_PC, m_pc);
    check({tag, ".top"},   ras_top, m_top());
    check({tag, ".cnt"},   32'(ras_cnt), 32'(m_ras.size()));
    check({tag, ".adel"},  32'(F_exc_adel), 32'(exp_adel(m_pc)));
  endtask

  // One clock: check ras_miss before the edge, advance the model, check state after.
  task automatic step(input string tag);
    logic        upd;
    logic [31:0] link;
    logic [31:0] off;
    #1;
    upd = !int_req && !stall;
    check({tag, ".miss"}, 32'(ras_miss),
          32'(D_ret && upd && (m_ras.size() == 0 || m_top() != D_ra)));
    link = D_PC + 32'd8;
    if (int_req)      m_pc = 32'h4180;
    else if (stall)   m_pc = m_pc;
    else if (eret)    m_pc = epc;
    else begin
      case (npc_sel)
        3'd0: m_pc = m_pc + 4;
        3'd1: begin
          off  = 32'($signed(D_imm16)) * 4;
          m_pc = D_bjump ? D_PC + 4 + off : m_pc + 4;
        end
        3'd2: m_pc = (D_PC & 32'hF000_0000) + 32'(D_imm26) * 4;
        3'd3: m_pc = D_ra;
        default: m_pc = 32'h3000;
      endcase
    end
    if (upd) begin
      if (D_ret && m_ras.size() > 0) void'(m_ras.pop_back());
      if (D_call) begin
        m_ras.push_back(link);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    logic [31:0] calls [5];
    calls = '{32'h3000, 32'h3010, 32'h3020, 32'h3030, 32'h3040};
    clear_inputs();
    reset = 1'b1;
    m_pc = 32'h3000;
    m_ras.delete();
    #2;
    check_state("reset");
    #10;
    reset = 1'b0;

    for (int i = 0; i < 3; i++) step("seq");
    check("seq_end", F_PC, 32'h300c);

    npc_sel = 3'd1; D_PC = 32'h3010; D_imm16 = 16'hFFFF; D_bjump = 1;
    step("br_taken");
    check("br_taken_abs", F_PC, 32'h3010);
    D_bjump = 0;
    step("br_not");

    npc_sel = 3'd2; D_imm26 = 26'h0000F00; stall = 1;
    step("stall1");
    step("stall2");
    int_req = 1;
    step("int_stall");
    check("int_abs", F_PC, 32'h4180);
    clear_inputs();

    eret = 1; epc = 32'h3040;
    step("eret");
    check("eret_abs", F_PC, 32'h3040);
    epc = 32'h3100; stall = 1;
    step("eret_st1");
    step("eret_st2");
    stall = 0;
    step("eret_go");
    clear_inputs();

    D_call = 1;
    for (int i = 0; i < 5; i++) begin D_PC = calls[i]; step("call"); end
    check("call_cnt", 32'(ras_cnt), 32'd4);
    check("call_top", ras_top, 32'h3048);
    D_call = 0; D_ret = 1; npc_sel = 3'd3;
    for (int i = 4; i >= 1; i--) begin
      D_ra = calls[i] + 8;
      #1;
      check("ret_hit", 32'(ras_miss), 32'd0);
      step("ret");
    end
    D_ra = 32'h3008;
    #1;
    check("ret_under", 32'(ras_miss), 32'd1);
    step("ret5");
    clear_inputs();

    npc_sel = 3'd3;
    D_ra = 32'h3002; step("jr_unal");
    D_ra = 32'h7000; step("jr_high");
    D_ra = 32'h3004; step("jr_ok");

    for (int i = 0; i < 400; i++) begin
      int_req = ($urandom_range(0, 19) == 0);
      stall   = ($urandom_range(0, 4) == 0);
      eret    = ($urandom_range(0, 9) == 0);
      epc     = 32'h3000 + ($urandom_range(0, 16'h0fff) << 2);
      npc_sel = 3'($urandom_range(0, 7));
      D_bjump = 1'($urandom);
      D_PC    = 32'h3000 + ($urandom_range(0, 16'h0fff) << 2);
      D_imm16 = 16'($urandom);
      D_imm26 = 26'($urandom);
      D_call  = ($urandom_range(0, 2) == 0);
      D_ret   = ($urandom_range(0, 2) == 0);
      D_ra    = ($urandom_range(0, 1) == 0) ? m_top() : 32'h3000 + ($urandom_range(0, 16'h0fff) << 2);
      if ($urandom_range(0, 15) == 0) D_ra = D_ra | 32'h2;
      step("rand");
    end

    D_call = 1; D_ret = 0; int_req = 0; stall = 0;
    step("pre_rst");
    reset = 1'b1;
    #2;
    m_pc = 32'h3000;
    m_ras.delete();
    check_state("async_rst");
    #2;
    reset = 1'b0;
    clear_inputs();
    step("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
